sparse_index_packer: RTL

Writer side of the sparse-operand memory. Scans a dense polynomial held in normal memory (MEM_SIZE words, WORD_WIDTH bits each), extracts the position of every set bit in ascending order, and packs positions two per word into sparse memory. Each packed word carries the smaller position in [31:16] and the larger in [15:0], the layout the sparse multiply controller consumes. Sits between the key/error generation path and the sparse-operand memory.

---
 rtl/sparse_index_packer.sv | 107 ++++++++++
 1 files changed

// File: rtl/sparse_index_packer.sv
// sparse_index_packer: scans dense memory and packs ascending set-bit positions two per sparse word
module sparse_index_packer #(
  parameter int WORD_WIDTH = 32,
  parameter int MEM_SIZE = 553,
  parameter int MEM_SPARSE_SIZE = 50
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_pack,
  input  logic [9:0]            sparse_base_i,
  input  logic [WORD_WIDTH-1:0] normal_mem_data,
  output logic [9:0]            normal_mem_addr_o,
  output logic [31:0]           sparse_mem_write_data,
  output logic                  sparse_mem_write_en,
  output logic [9:0]            sparse_mem_addr_o,
  output logic [9:0]            pair_count,
  output logic                  overflow,
  output logic                  pack_done,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, LOAD, SCAN, FLUSH} state_t;
  localparam logic [9:0] SPARSE_MAX = 10'(MEM_SPARSE_SIZE);
  localparam logic [9:0] LAST_WORD = 10'(MEM_SIZE - 1);
  state_t state;
  logic [WORD_WIDTH-1:0] word_reg;
  logic [9:0] word_idx;
  logic [15:0] hold_pos;
  logic [15:0] pos;
  logic pending;
  logic [4:0] low_bit;
  always_comb begin
    low_bit = '0;
    for (int i = WORD_WIDTH - 1; i >= 0; i--) low_bit = word_reg[i] ? 5'(i) : low_bit;
  end
  assign pos = {1'b0, word_idx, low_bit};
  // The write address advances the edge after a strobe so it stays stable while the strobe is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      word_reg <= '0;
      word_idx <= '0;
      hold_pos <= '0;
      pending <= 1'b0;
      normal_mem_addr_o <= '0;
      sparse_mem_write_data <= '0;
      sparse_mem_write_en <= 1'b0;
      sparse_mem_addr_o <= '0;
      pair_count <= '0;
      overflow <= 1'b0;
      pack_done <= 1'b0;
      busy <= 1'b0;
    end else begin
      sparse_mem_write_en <= 1'b0;
      pack_done <= 1'b0;
      if (sparse_mem_write_en) sparse_mem_addr_o <= sparse_mem_addr_o + 10'd1;
      case (state)
        IDLE: if (start_pack) begin
          busy <= 1'b1;
          normal_mem_addr_o <= '0;
          word_idx <= '0;
          sparse_mem_addr_o <= sparse_base_i;
          pair_count <= '0;
          overflow <= 1'b0;
          pending <= 1'b0;
          state <= LOAD;
        end
        LOAD: begin
          word_reg <= normal_mem_data;
          state <= SCAN;
        end
        SCAN: if (|word_reg) begin
          word_reg <= word_reg & (word_reg - WORD_WIDTH'(1));
          if (pending) begin
            sparse_mem_write_data <= {hold_pos, pos};
            sparse_mem_write_en <= 1'b1;
            pair_count <= pair_count + 10'd1;
            pending <= 1'b0;
          end else if (pair_count < SPARSE_MAX) begin
            hold_pos <= pos;
            pending <= 1'b1;
          end else begin
            overflow <= 1'b1;
            state <= FLUSH;
          end
        end else if (word_idx == LAST_WORD) begin
          state <= FLUSH;
        end else begin
          word_idx <= word_idx + 10'd1;
          normal_mem_addr_o <= normal_mem_addr_o + 10'd1;
          state <= LOAD;
        end
        FLUSH: begin
          if (pending) begin
            sparse_mem_write_data <= {hold_pos, 16'hFFFF};
            sparse_mem_write_en <= 1'b1;
            pair_count <= pair_count + 10'd1;
            pending <= 1'b0;
          end
          pack_done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
